regfile_read_arbiter: RTL and testbench

//  Shares one 32-to-1 register-file read mux among NUM_REQ requesters.

---
 rtl/regfile_read_arbiter_if.sv | 28 ++
 rtl/regfile_read_arbiter.sv | 92 +++++++++
 tb/tb_regfile_read_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_read_arbiter_if.sv
// Request/response bundle between read clients, the shared register-file mux and the read arbiter.
// master = clients + mux side, slave = arbiter side.
interface regfile_read_arbiter_if #(
  parameter int BUS_WIDTH = 32,
  parameter int SEL       = 5,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2
);
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ*SEL-1:0] req_addr;
  logic [NUM_REQ-1:0]     req_ready;
  logic [SEL-1:0]         Sel;
  logic [BUS_WIDTH-1:0]   Dout;
  logic                   rsp_valid;
  logic [BUS_WIDTH-1:0]   rsp_data;
  logic [ID_W-1:0]        rsp_id;
  logic                   rsp_ready;

  modport master (
    output req_valid, req_addr, Dout, rsp_ready,
    input  req_ready, Sel, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_addr, Dout, rsp_ready,
    output req_ready, Sel, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of one register-file read mux among NUM_REQ clients; optional RD_ARB_ZERO_REG_EN forces reads of reg 0 to zero.
// Latency: request accepted at edge k drives Sel in cycle k+1, response valid after edge k+1; one read per cycle.
// Backpressure: rsp_valid & ~rsp_ready freezes every register and withholds all grants.
module regfile_read_arbiter #(
  parameter int BUS_WIDTH = 32,
  parameter int SEL       = 5,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2
) (
  input logic                 Clk,
  input logic                 Rst,
  regfile_read_arbiter_if.slave bus
);

  logic                 stall;
  logic                 grant;
  logic [ID_W-1:0]      winner;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0]   onehot;
  logic [SEL-1:0]       win_addr;
  logic                 s1_valid;
  logic [ID_W-1:0]      s1_id;
  logic [BUS_WIDTH-1:0] load_data;

  assign stall = bus.rsp_valid & ~bus.rsp_ready;

  // Search starts at ptr and wraps; the first pending requester wins.
  always_comb begin
    int          idx;
    logic [ID_W-1:0] idx_w;
    grant  = 1'b0;
    winner = '0;
    onehot = '0;
    idx    = 0;
    idx_w  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_w = ID_W'(idx);
      if (!grant && bus.req_valid[idx_w]) begin
        grant  = 1'b1;
        winner = idx_w;
      end
    end
    if (grant) onehot[winner] = 1'b1;
  end

  assign win_addr = bus.req_addr[int'(winner)*SEL +: SEL];
  assign ptr_nxt  = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;

  assign bus.req_ready = (stall || Rst) ? '0 : onehot;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr      <= '0;
      s1_valid <= 1'b0;
      s1_id    <= '0;
      bus.Sel  <= '0;
    end else if (!stall) begin
      s1_valid <= grant;
      if (grant) begin
        bus.Sel <= win_addr;
        s1_id   <= winner;
        ptr     <= ptr_nxt;
      end
    end
  end

`ifdef RD_ARB_ZERO_REG_EN
  // Register 0 reads as constant zero regardless of what the mux returns.
  assign load_data = (bus.Sel == '0) ? '0 : bus.Dout;
`else
  assign load_data = bus.Dout;
`endif

  // A fire and a new load may coincide: stall is low whenever rsp_ready is high.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_id    <= '0;
    end else if (!stall) begin
      bus.rsp_valid <= s1_valid;
      if (s1_valid) begin
        bus.rsp_data <= load_data;
        bus.rsp_id   <= s1_id;
      end
    end
  end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: grant/response table plus hand sequences, data checked through a scoreboard.
module tb_regfile_read_arbiter;
  localparam int BW = 32;
  localparam int SW = 5;
  localparam int NR = 4;
  localparam int IW = 2;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  regfile_read_arbiter_if #(.BUS_WIDTH(BW), .SEL(SW), .NUM_REQ(NR), .ID_W(IW)) bus ();

  regfile_read_arbiter #(.BUS_WIDTH(BW), .SEL(SW), .NUM_REQ(NR), .ID_W(IW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  logic [BW-1:0] regs [32];
  logic [SW-1:0] addr_of [NR];
  assign bus.Dout = regs[bus.Sel];

  typedef struct {
    logic [3:0] vld;
    logic       rrdy;
    logic [3:0] exp_rdy;
    logic       exp_rvld;
    logic [1:0] exp_rid;
    logic       chk_sel;
    logic [4:0] exp_sel;
  } vec_t;
  vec_t tbl [23];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;
  exp_t sb [$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] exp_data(input logic [4:0] a);
`ifdef RD_ARB_ZERO_REG_EN
    exp_data = (a == 5'd0) ? 32'd0 : regs[a];
`else
    exp_data = regs[a];
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, then record accepted requests and consume a presented response.
  task automatic step(input logic rst, input logic [3:0] vld, input logic rrdy);
    exp_t e;
    @(negedge Clk);
    Rst = rst;
    bus.req_valid = vld;
    bus.rsp_ready = rrdy;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (vld[i] && bus.req_ready[i] === 1'b1) begin
        e.id   = 2'(i);
        e.data = exp_data(addr_of[i]);
        sb.push_back(e);
      end
    end
    if (bus.rsp_valid === 1'b1 && rrdy) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got response id %0d data %h expected none", bus.rsp_id, bus.rsp_data);
      end else begin
        e = sb.pop_front();
        check("sb_id", 32'(bus.rsp_id), 32'(e.id));
        check("sb_data", bus.rsp_data, e.data);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = (32'h0101_0101 * i) ^ 32'hA5A5_0000;
    regs[7]  = 32'hDEAD_BEEF;
    regs[0]  = 32'h1234_5678;
    addr_of[0] = 5'd7;
    addr_of[1] = 5'd19;
    addr_of[2] = 5'd24;
    addr_of[3] = 5'd0;
    bus.req_addr  = {addr_of[3], addr_of[2], addr_of[1], addr_of[0]};
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    Rst = 1'b1;

    //          vld      rrdy  exp_rdy  rvld  rid   chk   sel
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 5'd0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 5'd0};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b0, 5'd0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b0, 5'd0};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b0, 5'd0};
    tbl[5]  = '{4'b1110, 1'b1, 4'b0010, 1'b1, 2'd3, 1'b0, 5'd0};
    tbl[6]  = '{4'b1100, 1'b1, 4'b0100, 1'b1, 2'd0, 1'b0, 5'd0};
    tbl[7]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b0, 5'd0};
    tbl[8]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 2'd2, 1'b0, 5'd0};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd3, 1'b0, 5'd0};
    tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd1, 1'b0, 5'd0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 5'd0};
    tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 5'd0};
    tbl[13] = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 5'd0};
    tbl[14] = '{4'b1101, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 5'd0};
    tbl[15] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 5'd24};
    tbl[16] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 5'd24};
    tbl[17] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 5'd24};
    tbl[18] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd1, 1'b1, 5'd24};
    tbl[19] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b0, 5'd0};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0, 5'd0};
    tbl[21] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 5'd0};
    tbl[22] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 5'd0};

    // Reset with random request traffic
    step(1'b1, 4'($urandom_range(1, 15)), 1'b1);
    check("rst_grant0", 32'(bus.req_ready), 32'd0);
    step(1'b1, 4'($urandom_range(1, 15)), 1'b1);
    check("rst_grant1", 32'(bus.req_ready), 32'd0);
    check("rst_rvld", 32'(bus.rsp_valid), 32'd0);
    check("rst_sel", 32'(bus.Sel), 32'd0);
    check("rst_rdata", bus.rsp_data, 32'd0);
    check("rst_rid", 32'(bus.rsp_id), 32'd0);

    // Single read: grant, Sel next cycle, data the cycle after
    step(1'b0, 4'b0001, 1'b1);
    check("single_grant", 32'(bus.req_ready), 32'b0001);
    step(1'b0, 4'b0000, 1'b1);
    check("single_sel", 32'(bus.Sel), 32'd7);
    check("single_rvld_early", 32'(bus.rsp_valid), 32'd0);
    step(1'b0, 4'b0000, 1'b1);
    check("single_rvld", 32'(bus.rsp_valid), 32'd1);
    check("single_rdata", bus.rsp_data, 32'hDEAD_BEEF);
    check("single_rid", 32'(bus.rsp_id), 32'd0);
    step(1'b0, 4'b0000, 1'b1);
    check("single_rvld_drop", 32'(bus.rsp_valid), 32'd0);

    // Return pointer to zero, then run the table
    step(1'b1, 4'b0000, 1'b1);
    for (int n = 0; n < 23; n++) begin
      step(1'b0, tbl[n].vld, tbl[n].rrdy);
      check($sformatf("e%0d_grant", n), 32'(bus.req_ready), 32'(tbl[n].exp_rdy));
      check($sformatf("e%0d_rvld", n), 32'(bus.rsp_valid), 32'(tbl[n].exp_rvld));
      if (tbl[n].exp_rvld) check($sformatf("e%0d_rid", n), 32'(bus.rsp_id), 32'(tbl[n].exp_rid));
      if (tbl[n].chk_sel) check($sformatf("e%0d_sel", n), 32'(bus.Sel), 32'(tbl[n].exp_sel));
    end

    // Register 0 read
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
`ifdef RD_ARB_ZERO_REG_EN
    check("zero_rdata", bus.rsp_data, 32'd0);
`else
    check("zero_rdata", bus.rsp_data, 32'h1234_5678);
`endif
    check("zero_rid", 32'(bus.rsp_id), 32'd3);
    step(1'b0, 4'b0000, 1'b1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset while a response is pending: it is discarded
    step(1'b0, 4'b0010, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b0000, 1'b0);
    check("midrst_rvld_before", 32'(bus.rsp_valid), 32'd1);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b1);
    check("midrst_rvld", 32'(bus.rsp_valid), 32'd0);
    check("midrst_rdata", bus.rsp_data, 32'd0);
    check("midrst_sel", 32'(bus.Sel), 32'd0);
    check("midrst_pending", 32'(sb.size()), 32'd1);
    sb.delete();
    step(1'b0, 4'b0000, 1'b1);
    check("midrst_quiet", 32'(bus.rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
